// File: rtl/bkm_pkg.sv
// Shared encodings and helpers for the BKM iteration controller.
// Digit, format and FSM state codes plus the residual threshold function.
package bkm_pkg;

  localparam logic [1:0] DIGIT_ZERO = 2'b00;
  localparam logic [1:0] DIGIT_POS  = 2'b01;
  localparam logic [1:0] DIGIT_NEG  = 2'b11;

  localparam logic [1:0] FORMAT_0       = 2'b00;
  localparam logic [1:0] FORMAT_1       = 2'b01;
  localparam logic [1:0] FORMAT_2       = 2'b10;
  localparam logic [1:0] FORMAT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Residual magnitude at which a nonzero digit is selected: 2^(w-3).
  function automatic int bkm_threshold(input int w);
    return 1 << (w - 3);
  endfunction

  function automatic logic [1:0] digit_negate(input logic [1:0] d);
    logic [1:0] res;
    res = DIGIT_ZERO;
    if (d == DIGIT_POS) res = DIGIT_NEG;
    else if (d == DIGIT_NEG) res = DIGIT_POS;
    return res;
  endfunction

endpackage

// File: rtl/bkm_digit_sel.sv
// Signed-digit selector: compares a two's complement residual against +/-T.
// mode = 1 (L-mode) negates the selected digit.
module bkm_digit_sel
  import bkm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic         mode,
  output logic [1:0]   d
);

  localparam int              T_INT = bkm_threshold(W);
  localparam logic [W-1:0]    T_POS = W'(T_INT);
  localparam logic [W-1:0]    T_NEG = W'(-T_INT);

  logic signed [W-1:0] rs;
  logic [1:0]          d_e;

  assign rs = $signed(r);

  always_comb begin
    d_e = DIGIT_ZERO;
    if (rs >= $signed(T_POS)) d_e = DIGIT_POS;
    else if (rs < $signed(T_NEG)) d_e = DIGIT_NEG;
  end

  assign d = mode ? digit_negate(d_e) : d_e;

endmodule

// File: rtl/bkm_iter_ctrl.sv
// BKM iteration sequencer driving bkm_step: LOAD, then N ITER cycles, then DONE.
// Optional macro BKM_ITER_CTRL_B2B_EN allows a new start in DONE (no IDLE bubble).
module bkm_iter_ctrl
  import bkm_pkg::*;
#(
  parameter int W     = 8,
  parameter int LOG2W = 3,
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             enable,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             mode,
  input  logic [1:0]       format,
  input  logic [W-1:0]     u_fb,
  input  logic [W-1:0]     v_fb,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [1:0]       step_d_x,
  output logic [1:0]       step_d_y,
  output logic             step_load,
  output logic             step_ena,
  output logic [LOG2N-1:0] lut_addr,
  output logic             busy,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_err,
  output state_t           dbg_state
);

  if (W != (1 << LOG2W)) begin : g_bad_w
    $error("bkm_iter_ctrl: W must equal 2**LOG2W");
  end
  if (N != (1 << LOG2N)) begin : g_bad_n
    $error("bkm_iter_ctrl: N must equal 2**LOG2N");
  end

  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  state_t           state;
  logic [LOG2N-1:0] cnt;
  logic             mode_q;
  logic [1:0]       format_q;
  logic             err_q;
  logic [1:0]       d_x_raw;
  logic [1:0]       d_y_raw;
  logic             start_acc;
  logic             done_acc;

  // Handshake: a transfer completes on an edge where valid && ready && enable.
  // start_ready is 1 in IDLE (and in DONE mirrors done_ready when back-to-back
  // is built in); done_valid is 1 in DONE and holds until done_ready.
`ifdef BKM_ITER_CTRL_B2B_EN
  assign start_ready = (state == ST_IDLE) || ((state == ST_DONE) && done_ready);
`else
  assign start_ready = (state == ST_IDLE);
`endif

  assign busy       = (state == ST_LOAD) || (state == ST_ITER);
  assign done_valid = (state == ST_DONE);
  assign done_err   = err_q;
  assign start_acc  = start_valid && start_ready && enable;
  assign done_acc   = done_valid && done_ready && enable;

  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mode_q   <= 1'b0;
      format_q <= 2'b00;
      err_q    <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            mode_q   <= mode;
            format_q <= format;
            cnt      <= '0;
            if (format == FORMAT_ILLEGAL) begin
              state <= ST_DONE;
              err_q <= 1'b1;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          state <= ST_ITER;
          cnt   <= '0;
        end
        ST_ITER: begin
          if (cnt == CNT_LAST) state <= ST_DONE;
          else                 cnt   <= cnt + 1'b1;
        end
        ST_DONE: begin
          if (done_acc) begin
            err_q <= 1'b0;
            // start_acc can only be true here in the back-to-back build.
            if (start_acc) begin
              mode_q   <= mode;
              format_q <= format;
              cnt      <= '0;
              if (format == FORMAT_ILLEGAL) begin
                state <= ST_DONE;
                err_q <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bkm_digit_sel #(.W(W)) u_sel_x (.r(u_fb), .mode(mode_q), .d(d_x_raw));
  bkm_digit_sel #(.W(W)) u_sel_y (.r(v_fb), .mode(mode_q), .d(d_y_raw));

  assign step_mode   = mode_q;
  assign step_format = format_q;
  assign step_n      = (state == ST_ITER) ? cnt : '0;
  assign lut_addr    = step_n;
  assign step_d_x    = (state == ST_ITER) ? d_x_raw : DIGIT_ZERO;
  assign step_d_y    = (state == ST_ITER) ? d_y_raw : DIGIT_ZERO;
  assign step_load   = enable && (state == ST_LOAD);
  assign step_ena    = enable && ((state == ST_LOAD) || (state == ST_ITER));
  assign dbg_state   = state;

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Directed bench for bkm_iter_ctrl (W=8, N=8) with hand-computed expectations.
// Back-to-back checks follow BKM_ITER_CTRL_B2B_EN.
module tb_bkm_iter_ctrl;
  import bkm_pkg::*;

  logic       clk = 1'b0;
  logic       arst, enable, start_valid, start_ready, mode;
  logic [1:0] format;
  logic [7:0] u_fb, v_fb;
  logic       step_mode;
  logic [1:0] step_format, step_d_x, step_d_y;
  logic [2:0] step_n, lut_addr;
  logic       step_load, step_ena, busy, done_valid, done_ready, done_err;
  state_t     dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bkm_iter_ctrl #(.W(8), .LOG2W(3), .N(8), .LOG2N(3)) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .start_valid(start_valid), .start_ready(start_ready),
    .mode(mode), .format(format), .u_fb(u_fb), .v_fb(v_fb),
    .step_mode(step_mode), .step_format(step_format), .step_n(step_n),
    .step_d_x(step_d_x), .step_d_y(step_d_y), .step_load(step_load),
    .step_ena(step_ena), .lut_addr(lut_addr), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic m, input logic [1:0] f);
    mode        = m;
    format      = f;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic finish_op();
    int k;
    k = 0;
    while (!done_valid && k < 20) begin
      tick();
      k++;
    end
    chk("finish_timeout", {31'd0, done_valid}, 32'd1);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("finish_idle", {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] tu [4];
    logic [1:0] td [4];
    tu = '{8'd32, 8'd31, 8'hE0, 8'hDF};
    td = '{2'b01, 2'b00, 2'b00, 2'b11};

    arst = 1'b1; enable = 1'b1; start_valid = 1'b0; mode = 1'b0;
    format = 2'b00; u_fb = 8'd0; v_fb = 8'd0; done_ready = 1'b0;
    tick();
    tick();
    arst = 1'b0;
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_busy",        {31'd0, busy}, 32'd0);
    chk("rst_done_valid",  {31'd0, done_valid}, 32'd0);
    chk("rst_step_ena",    {31'd0, step_ena}, 32'd0);
    chk("rst_step_n",      {29'd0, step_n}, 32'd0);
    chk("rst_done_err",    {31'd0, done_err}, 32'd0);

    // Nominal E-mode run
    u_fb = 8'd40; v_fb = 8'hDF;
    #1;
    chk("idle_dx_forced", {30'd0, step_d_x}, 32'd0);
    do_start(1'b0, 2'b00);
    chk("load_step_load", {31'd0, step_load}, 32'd1);
    chk("load_step_ena",  {31'd0, step_ena}, 32'd1);
    chk("load_step_n",    {29'd0, step_n}, 32'd0);
    chk("load_dx",        {30'd0, step_d_x}, 32'd0);
    chk("load_busy",      {31'd0, busy}, 32'd1);
    chk("load_start_rdy", {31'd0, start_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("iter_step_n", {29'd0, step_n}, 32'(i));
      chk("iter_lut",    {29'd0, lut_addr}, 32'(i));
      chk("iter_ena",    {31'd0, step_ena}, 32'd1);
      chk("iter_load",   {31'd0, step_load}, 32'd0);
      chk("iter_dx",     {30'd0, step_d_x}, 32'h1);
      chk("iter_dy",     {30'd0, step_d_y}, 32'h3);
    end
    tick();
    chk("nom_done_valid", {31'd0, done_valid}, 32'd1);
    chk("nom_done_err",   {31'd0, done_err}, 32'd0);
    chk("nom_busy",       {31'd0, busy}, 32'd0);
    chk("nom_done_ena",   {31'd0, step_ena}, 32'd0);
    chk("nom_done_dx",    {30'd0, step_d_x}, 32'd0);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("nom_idle_dv", {31'd0, done_valid}, 32'd0);
    chk("nom_idle_sr", {31'd0, start_ready}, 32'd1);

    // E-mode thresholds around T = 32
    do_start(1'b0, 2'b01);
    tick();
    chk("thr_format", {30'd0, step_format}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      u_fb = tu[i];
      #1;
      chk("thr_e_dx", {30'd0, step_d_x}, {30'd0, td[i]});
    end
    finish_op();

    // L-mode negates the digit
    do_start(1'b1, 2'b10);
    tick();
    u_fb = 8'd40; v_fb = 8'hDF;
    #1;
    chk("lmode_dx",   {30'd0, step_d_x}, 32'h3);
    chk("lmode_dy",   {30'd0, step_d_y}, 32'h1);
    chk("lmode_mode", {31'd0, step_mode}, 32'd1);
    u_fb = 8'd0;
    #1;
    chk("lmode_dx0",  {30'd0, step_d_x}, 32'h0);
    finish_op();
    u_fb = 8'd40;

    // Illegal format goes straight to DONE with error
    do_start(1'b0, 2'b11);
    chk("ill_done_valid", {31'd0, done_valid}, 32'd1);
    chk("ill_done_err",   {31'd0, done_err}, 32'd1);
    chk("ill_step_ena",   {31'd0, step_ena}, 32'd0);
    chk("ill_busy",       {31'd0, busy}, 32'd0);
    chk("ill_format",     {30'd0, step_format}, 32'h3);
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("ill_err_clr", {31'd0, done_err}, 32'd0);
    chk("ill_dv_clr",  {31'd0, done_valid}, 32'd0);

    // enable low for 3 cycles at step_n = 4
    do_start(1'b0, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_pre_n", {29'd0, step_n}, 32'd4);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_n",    {29'd0, step_n}, 32'd4);
      chk("stall_ena",  {31'd0, step_ena}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_c12_dv", {31'd0, done_valid}, 32'd0);
    tick();
    chk("stall_c13_dv", {31'd0, done_valid}, 32'd1);
    done_ready = 1'b1;
    enable = 1'b0;
    tick();
    chk("stall_done_hold", {31'd0, done_valid}, 32'd1);
    enable = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("stall_done_rel", {31'd0, done_valid}, 32'd0);

    // arst mid-ITER discards the operation
    do_start(1'b0, 2'b00);
    for (int i = 0; i < 6; i++) tick();
    chk("arst_pre_n", {29'd0, step_n}, 32'd5);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("arst_step_n", {29'd0, step_n}, 32'd0);
    chk("arst_busy",   {31'd0, busy}, 32'd0);
    chk("arst_sr",     {31'd0, start_ready}, 32'd1);
    chk("arst_ena",    {31'd0, step_ena}, 32'd0);
    chk("arst_state",  {30'd0, dbg_state}, {30'd0, ST_IDLE});
    do_start(1'b0, 2'b00);
    for (int i = 0; i < 8; i++) tick();
    chk("arst_c9_dv",  {31'd0, done_valid}, 32'd0);
    tick();
    chk("arst_c10_dv", {31'd0, done_valid}, 32'd1);

    // done_ready held low 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_dv", {31'd0, done_valid}, 32'd1);
      chk("hold_sr", {31'd0, start_ready}, 32'd0);
    end
`ifdef BKM_ITER_CTRL_B2B_EN
    done_ready = 1'b1;
    start_valid = 1'b1;
    mode = 1'b1;
    format = 2'b10;
    #1;
    chk("b2b_sr", {31'd0, start_ready}, 32'd1);
    tick();
    start_valid = 1'b0;
    done_ready = 1'b0;
    chk("b2b_load",   {31'd0, step_load}, 32'd1);
    chk("b2b_busy",   {31'd0, busy}, 32'd1);
    chk("b2b_mode",   {31'd0, step_mode}, 32'd1);
    chk("b2b_format", {30'd0, step_format}, 32'h2);
    finish_op();
`else
    done_ready = 1'b1;
    start_valid = 1'b1;
    #1;
    chk("nob2b_sr", {31'd0, start_ready}, 32'd0);
    tick();
    start_valid = 1'b0;
    done_ready = 1'b0;
    chk("nob2b_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    chk("nob2b_load", {31'd0, step_load}, 32'd0);
    chk("nob2b_dv",   {31'd0, done_valid}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
